// File: rtl/pong_pkg.sv
// Shared Pong dimensions, ball state encoding and direction type.
package pong_pkg;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int BALL_SIZE   = 8;
    localparam int PADDLE_W    = 8;
    localparam int PADDLE_H    = 64;
    localparam int PLAYER_X    = 16;
    localparam int AI_X        = 616;
    localparam int SPEED       = 2;
    localparam int SERVE_DELAY = 60;
    localparam int WIN_SCORE   = 7;

    // 11-bit forms of the geometry so the datapath never wraps
    localparam logic [10:0] B_SZ        = 11'(BALL_SIZE);
    localparam logic [10:0] P_H         = 11'(PADDLE_H);
    localparam logic [10:0] SPD         = 11'(SPEED);
    localparam logic [10:0] X_MAX       = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX       = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] X_CTR       = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] Y_CTR       = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] AI_FACE     = 11'(AI_X);
    localparam logic [10:0] AI_HIT_X    = 11'(AI_X - BALL_SIZE);
    localparam logic [10:0] PLAYER_FACE = 11'(PLAYER_X + PADDLE_W);
    localparam logic [5:0]  SERVE_LAST  = 6'(SERVE_DELAY - 1);
    localparam logic [3:0]  WIN_SC      = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        SCORED    = 2'd2,
        GAME_OVER = 2'd3
    } ball_state_t;

    // INC = right / down, DEC = left / up
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    // Vertical overlap of the ball with a paddle whose top is at py
    function automatic logic overlap(input logic [10:0] by, input logic [10:0] py);
        return (by + B_SZ > py) && (by < py + P_H);
    endfunction
endpackage

// File: rtl/ball_collide.sv
// Next-position logic for one frame of play: wall bounce, paddle hit, miss detect.
module ball_collide
    import pong_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  dir_t        dir_x,
    input  dir_t        dir_y,
    input  logic [10:0] player_paddle,
    input  logic [10:0] ai_paddle,
    output logic [10:0] x_next,
    output logic [10:0] y_next,
    output dir_t        dir_x_next,
    output dir_t        dir_y_next,
    output logic        player_miss,
    output logic        ai_miss
);
    // Vertical axis: clamp at the walls and flip on reaching them
    always_comb begin
        y_next     = y;
        dir_y_next = dir_y;
        if (dir_y == DIR_INC) begin
            if (y + SPD >= Y_MAX) begin
                y_next     = Y_MAX;
                dir_y_next = DIR_DEC;
            end else begin
                y_next = y + SPD;
            end
        end else begin
            if (y <= SPD) begin
                y_next     = '0;
                dir_y_next = DIR_INC;
            end else begin
                y_next = y - SPD;
            end
        end
    end

    // Horizontal axis: paddle face check first, then miss at the edge, else advance
    always_comb begin
        x_next      = x;
        dir_x_next  = dir_x;
        player_miss = 1'b0;
        ai_miss     = 1'b0;
        if (dir_x == DIR_INC) begin
            if ((x + B_SZ <= AI_FACE) && (x + SPD + B_SZ >= AI_FACE) && overlap(y, ai_paddle)) begin
                x_next     = AI_HIT_X;
                dir_x_next = DIR_DEC;
            end else if (x == X_MAX) begin
                player_miss = 1'b1;
            end else if (x + SPD >= X_MAX) begin
                x_next = X_MAX;
            end else begin
                x_next = x + SPD;
            end
        end else begin
            if ((x >= PLAYER_FACE) && (x <= PLAYER_FACE + SPD) && overlap(y, player_paddle)) begin
                x_next     = PLAYER_FACE;
                dir_x_next = DIR_INC;
            end else if (x == '0) begin
                ai_miss = 1'b1;
            end else if (x <= SPD) begin
                x_next = '0;
            end else begin
                x_next = x - SPD;
            end
        end
    end
endmodule

// File: rtl/ball_motion.sv
// Pong ball engine: serve/play/point/game-over sequencing, scores and ball position.
module ball_motion
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] player_paddle,
    input  logic [9:0] ai_paddle,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [1:0] ball_state,
    output logic       player_point,
    output logic       ai_point,
    output logic [3:0] player_score,
    output logic [3:0] ai_score
);
    ball_state_t state;
    logic [10:0] x, y;
    dir_t        dir_x, dir_y;
    logic [5:0]  serve_cnt;

    logic [10:0] x_next, y_next;
    dir_t        dir_x_next, dir_y_next;
    logic        player_miss, ai_miss;

    ball_collide u_collide (
        .x             (x),
        .y             (y),
        .dir_x         (dir_x),
        .dir_y         (dir_y),
        .player_paddle ({1'b0, player_paddle}),
        .ai_paddle     ({1'b0, ai_paddle}),
        .x_next        (x_next),
        .y_next        (y_next),
        .dir_x_next    (dir_x_next),
        .dir_y_next    (dir_y_next),
        .player_miss   (player_miss),
        .ai_miss       (ai_miss)
    );

    // Game FSM: everything advances on frame_tick only; point pulses self-clear each clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SERVE;
            x            <= X_CTR;
            y            <= Y_CTR;
            dir_x        <= DIR_INC;
            dir_y        <= DIR_INC;
            serve_cnt    <= '0;
            player_score <= '0;
            ai_score     <= '0;
            player_point <= 1'b0;
            ai_point     <= 1'b0;
        end else begin
            player_point <= 1'b0;
            ai_point     <= 1'b0;
            if (frame_tick) begin
                case (state)
                    SERVE: begin
                        if (serve_cnt == SERVE_LAST) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 6'd1;
                        end
                    end
                    PLAY: begin
                        if (player_miss) begin
                            player_score <= player_score + 4'd1;
                            player_point <= 1'b1;
                            state        <= (player_score + 4'd1 == WIN_SC) ? GAME_OVER : SCORED;
                        end else if (ai_miss) begin
                            ai_score <= ai_score + 4'd1;
                            ai_point <= 1'b1;
                            state    <= (ai_score + 4'd1 == WIN_SC) ? GAME_OVER : SCORED;
                        end else begin
                            x     <= x_next;
                            y     <= y_next;
                            dir_x <= dir_x_next;
                            dir_y <= dir_y_next;
                        end
                    end
                    SCORED: begin
                        // dir_x was held through the miss, so it already points at the conceder
                        x     <= X_CTR;
                        y     <= Y_CTR;
                        dir_y <= DIR_INC;
                        state <= SERVE;
                    end
                    GAME_OVER: begin
                        x <= X_CTR;
                        y <= Y_CTR;
                    end
                endcase
            end
        end
    end

    assign ball_pos_x = x[9:0];
    assign ball_pos_y = y[9:0];
    assign ball_state = state;
endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: behavioural model feeds a scoreboard queue.
module tb_ball_motion;
    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [9:0] player_paddle, ai_paddle;
    logic [9:0] ball_pos_x, ball_pos_y;
    logic [1:0] ball_state;
    logic       player_point, ai_point;
    logic [3:0] player_score, ai_score;

    int vectors = 0;
    int miscompares = 0;

    ball_motion dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .player_paddle (player_paddle),
        .ai_paddle     (ai_paddle),
        .ball_pos_x    (ball_pos_x),
        .ball_pos_y    (ball_pos_y),
        .ball_state    (ball_state),
        .player_point  (player_point),
        .ai_point      (ai_point),
        .player_score  (player_score),
        .ai_score      (ai_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int st; int pp; int ap; int ps; int as;
    } exp_t;
    exp_t sbq[$];

    // model state
    int mx, my, mdx, mdy, mst, mcnt, mps, mas, mpp_o, map_o, m_serve_dir;
    bit m_phit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        mx = 316; my = 236; mdx = 1; mdy = 1; mst = 0; mcnt = 0;
        mps = 0; mas = 0; mpp_o = 0; map_o = 0; m_serve_dir = 1;
    endtask

    task automatic m_step(input bit ft, input int pp, input int ap);
        int nx, ny, ndx, ndy;
        bit pmiss, amiss;
        mpp_o = 0; map_o = 0;
        if (!ft) return;
        case (mst)
            0: if (mcnt == 59) begin mcnt = 0; mst = 1; end else mcnt++;
            1: begin
                ndy = mdy;
                if (mdy == 1) begin
                    ny = my + 2;
                    if (ny >= 472) begin ny = 472; ndy = -1; end
                end else begin
                    ny = my - 2;
                    if (ny <= 0) begin ny = 0; ndy = 1; end
                end
                ndx = mdx; nx = mx; pmiss = 0; amiss = 0;
                if (mdx == 1) begin
                    if (mx + 8 <= 616 && mx + 10 >= 616 && my + 8 > ap && my < ap + 64) begin
                        nx = 608; ndx = -1;
                    end else if (mx == 632) pmiss = 1;
                    else nx = (mx + 2 > 632) ? 632 : mx + 2;
                end else begin
                    if (mx >= 24 && mx - 2 <= 24 && my + 8 > pp && my < pp + 64) begin
                        nx = 24; ndx = 1; m_phit = 1;
                    end else if (mx == 0) amiss = 1;
                    else nx = (mx - 2 < 0) ? 0 : mx - 2;
                end
                if (pmiss) begin
                    mps++; mpp_o = 1; mst = (mps == 7) ? 3 : 2; m_serve_dir = 1;
                end else if (amiss) begin
                    mas++; map_o = 1; mst = (mas == 7) ? 3 : 2; m_serve_dir = -1;
                end else begin
                    mx = nx; my = ny; mdx = ndx; mdy = ndy;
                end
            end
            2: begin mx = 316; my = 236; mdy = 1; mdx = m_serve_dir; mst = 0; end
            default: begin mx = 316; my = 236; end
        endcase
    endtask

    // one clk: drive frame_tick, push model expectation, compare one clk later
    task automatic step(input bit ft);
        exp_t e;
        frame_tick = ft;
        m_step(ft, int'(player_paddle), int'(ai_paddle));
        e = '{mx, my, mst, mpp_o, map_o, mps, mas};
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk("x", 32'(ball_pos_x), e.x);
        chk("y", 32'(ball_pos_y), e.y);
        chk("state", 32'(ball_state), e.st);
        chk("player_point", 32'(player_point), e.pp);
        chk("ai_point", 32'(ai_point), e.ap);
        chk("player_score", 32'(player_score), e.ps);
        chk("ai_score", 32'(ai_score), e.as);
    endtask

    task automatic frame();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(ball_pos_x), 316);
        chk({tag, "_y"}, 32'(ball_pos_y), 236);
        chk({tag, "_state"}, 32'(ball_state), 0);
        chk({tag, "_pscore"}, 32'(player_score), 0);
        chk({tag, "_ascore"}, 32'(ai_score), 0);
        chk({tag, "_ppulse"}, 32'(player_point), 0);
        chk({tag, "_apulse"}, 32'(ai_point), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, t;
        reset = 1'b1; frame_tick = 1'b0; player_paddle = 10'd240; ai_paddle = 10'd240;
        m_reset(); m_phit = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // --- scenario A: serve, wall bounce, AI paddle hit, rally, AI scores
        repeat (59) frame();
        chk("srv59_state", 32'(ball_state), 0);
        frame();
        chk("srv60_state", 32'(ball_state), 1);
        chk("srv60_x", 32'(ball_pos_x), 316);
        frame();
        chk("play1_x", 32'(ball_pos_x), 318);
        chk("play1_y", 32'(ball_pos_y), 238);
        repeat (117) frame();
        chk("play118_y", 32'(ball_pos_y), 472);
        chk("play118_x", 32'(ball_pos_x), 552);
        frame();
        chk("play119_y", 32'(ball_pos_y), 470);
        ai_paddle = 10'd400;
        repeat (27) frame();
        chk("play146_x", 32'(ball_pos_x), 608);
        chk("play146_y", 32'(ball_pos_y), 416);
        frame();
        chk("play147_x", 32'(ball_pos_x), 606);

        // player tracks until it returns the ball once, then misses; AI always tracks
        n = 0;
        while (mas == 0 && n < 2000) begin
            t = (my >= 28) ? my - 28 : 0;
            ai_paddle = 10'(t);
            player_paddle = m_phit ? 10'd1000 : 10'(t);
            frame();
            n++;
        end
        chk("rally_done", 32'(mas == 1), 1);
        chk("player_hit_seen", 32'(m_phit), 1);
        chk("ai_score_1", 32'(ai_score), 1);
        chk("scored_state", 32'(ball_state), 2);
        frame();
        chk("after_ai_pt_state", 32'(ball_state), 0);
        chk("after_ai_pt_x", 32'(ball_pos_x), 316);
        repeat (61) frame();
        chk("serve_to_player_x", 32'(ball_pos_x), 314);

        // --- scenario B: continuous frame_tick, player scores on every serve
        frame_tick = 1'b0; player_paddle = 10'd240; ai_paddle = 10'd0;
        reset = 1'b1; m_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (60) step(1'b1);
        chk("cont_play_state", 32'(ball_state), 1);
        repeat (158) step(1'b1);
        chk("edge_x", 32'(ball_pos_x), 632);
        step(1'b1);
        chk("miss_ppulse", 32'(player_point), 1);
        chk("miss_pscore", 32'(player_score), 1);
        chk("miss_state", 32'(ball_state), 2);
        step(1'b1);
        chk("recentre_state", 32'(ball_state), 0);
        chk("recentre_x", 32'(ball_pos_x), 316);
        chk("pulse_cleared", 32'(player_point), 0);
        repeat (70) step(1'b1);
        chk("mid_play_state", 32'(ball_state), 1);

        // async reset between edges, mid-play with a nonzero score
        frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        m_reset();
        @(negedge clk);
        reset = 1'b0;

        n = 0;
        while (mst != 3 && n < 3000) begin
            step(1'b1);
            n++;
        end
        chk("game_over_state", 32'(ball_state), 3);
        chk("game_over_pscore", 32'(player_score), 7);
        repeat (5) step(1'b1);
        chk("frozen_state", 32'(ball_state), 3);
        chk("frozen_pscore", 32'(player_score), 7);
        chk("frozen_x", 32'(ball_pos_x), 316);
        chk("frozen_y", 32'(ball_pos_y), 236);

        frame_tick = 1'b0;
        reset = 1'b1; m_reset();
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("final_rst");
        repeat (3) frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
